// File: rtl/axils_rd_ch.sv
// axils_rd_ch: AXI4-Lite slave read channel in front of a local register bank.
// Accepts one AR at a time, decodes the 2^RANGE_W byte window at BASE_ADDR and
// fetches one word over the REG_RD_* port. It answers OKAY/SLVERR from the
// local port, or DECERR without any local access for addresses outside the
// window.
// Optional build macro AXILS_RD_TIMEOUT_EN: adds a REG_WAIT watchdog that
// forces SLVERR after TIMEOUT_CYC cycles without a local acknowledge.
module axils_rd_ch #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RANGE_W     = 12,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [ADDR_W-1:0]    ARADDR,
  input  logic [2:0]           ARPROT,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [31:0]          RDATA,
  output logic [1:0]           RRESP,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic                 REG_RD_REQ,
  output logic [RANGE_W-3:0]   REG_RD_ADDR,
  input  logic [31:0]          REG_RD_DATA,
  input  logic                 REG_RD_ACK,
  input  logic                 REG_RD_ERR
);

  typedef enum logic [1:0] {IDLE, REG_WAIT, RESP} state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                req_q, req_d;
  logic [RANGE_W-3:0]  addr_q, addr_d;

  logic                ar_hs;
  logic                in_win;
  logic                timeout_hit;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_w;
  assign unused_w = ^{ARPROT, ARADDR[1:0]};

  // ARREADY is only ever high in IDLE, so this is the single accept point.
  assign ar_hs  = (state_q == IDLE) && ARVALID && arready_q;
  assign in_win = (ARADDR[ADDR_W-1:RANGE_W] == BASE_ADDR[ADDR_W-1:RANGE_W]);

`ifdef AXILS_RD_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Watchdog count: cleared on accept, advances on every unacknowledged wait cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs) begin
      cnt_d = '0;
    end else if ((state_q == REG_WAIT) && !REG_RD_ACK) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An acknowledge in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state_q == REG_WAIT) && !REG_RD_ACK && (cnt_q == TO_LAST);
`else
  logic unused_to_w;
  assign unused_to_w = ^TO_LAST;
  assign timeout_hit = 1'b0;
`endif

  // State and registered-output storage.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      req_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = in_win ? REG_WAIT : RESP;
        end
      end
      REG_WAIT: begin
        if (REG_RD_ACK || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (RREADY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; local ack/data/err only matter in REG_WAIT.
  always_comb begin
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    req_d     = 1'b0;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          if (in_win) begin
            addr_d = ARADDR[RANGE_W-1:2];
            req_d  = 1'b1;
          end else begin
            rdata_d  = '0;
            rresp_d  = RESP_DECERR;
            rvalid_d = 1'b1;
          end
        end
      end
      REG_WAIT: begin
        if (REG_RD_ACK) begin
          rdata_d  = REG_RD_DATA;
          rresp_d  = REG_RD_ERR ? RESP_SLVERR : RESP_OKAY;
          rvalid_d = 1'b1;
        end else if (timeout_hit) begin
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
        end
      end
      RESP: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: begin
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  assign ARREADY     = arready_q;
  assign RVALID      = rvalid_q;
  assign RDATA       = rdata_q;
  assign RRESP       = rresp_q;
  assign REG_RD_REQ  = req_q;
  assign REG_RD_ADDR = addr_q;

endmodule

// File: doc/axils_rd_ch.md
Name: axils_rd_ch

Overview:
AXI4-Lite slave read-channel responder. It is the downstream consumer of the AXI4-Lite master read channel: it accepts AR transfers, decodes the address window and fetches one word over a simple local register-read port. It then returns the R beat with OKAY, SLVERR or DECERR. There is at most one outstanding transaction, and it sits in front of peripheral register banks.

Parameters:
ADDR_W, 32, ARADDR width (>= RANGE_W+1)
BASE_ADDR, 32'h0000_0000, window base; only bits [ADDR_W-1:RANGE_W] are compared
RANGE_W, 12, window size is 2^RANGE_W bytes
TIMEOUT_CYC, 256, REG_WAIT cycles before forced SLVERR (used only with the optional feature); range 2..65535

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  synchronous reset, active-high
ARADDR  in  ADDR_W  read address
ARPROT  in  3  protection; accepted and ignored
ARVALID  in  1  address valid
ARREADY  out  1  address ready (registered)
RDATA  out  32  read data (registered)
RRESP  out  2  read response (registered)
RVALID  out  1  read data valid (registered)
RREADY  in  1  master ready for data
REG_RD_REQ  out  1  one-cycle local read strobe
REG_RD_ADDR  out  RANGE_W-2  word address inside window
REG_RD_DATA  in  32  local read data, sampled with ACK
REG_RD_ACK  in  1  local read done, may assert in the REG_RD_REQ cycle or later
REG_RD_ERR  in  1  local error, sampled with ACK

Behaviour:
- Clock and reset: one clock ACLK; reset ARESET is synchronous and active-high.
- Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, REG_RD_REQ=0, REG_RD_ADDR=0; state=IDLE. ARREADY rises in the first clock after ARESET deasserts.
- States: IDLE, REG_WAIT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY, ARREADY<=0.
  - In-window (ARADDR[ADDR_W-1:RANGE_W]==BASE_ADDR[ADDR_W-1:RANGE_W]): REG_RD_ADDR<=ARADDR[RANGE_W-1:2], REG_RD_REQ<=1, go to REG_WAIT.
  - Out-of-window: RDATA<=0, RRESP<=2'b11 (DECERR), RVALID<=1, go to RESP. No local access.
  - ARADDR[1:0] is ignored (no alignment error).
- REG_WAIT:
  - REG_RD_REQ is high for exactly the first cycle only. REG_RD_ADDR holds until the next accept.
  - On REG_RD_ACK: RDATA<=REG_RD_DATA, RRESP<=REG_RD_ERR ? 2'b10 : 2'b00, RVALID<=1, go to RESP.
  - ACK in the same cycle as REG_RD_REQ is legal.
- RESP:
  - RVALID, RDATA and RRESP are held stable until RREADY.
  - On RVALID&RREADY: RVALID<=0, ARREADY<=1, go to IDLE.
  - The next AR can be accepted no earlier than the cycle after the R handshake.
- Latency, with the AR handshake at cycle N:
  - REG_RD_REQ is high in cycle N+1.
  - ACK at N+1 gives RVALID at N+2.
  - DECERR gives RVALID at N+1.
- REG_RD_ACK/ERR/DATA are ignored outside REG_WAIT (stray or late acks have no effect).
- ARVALID asserted while ARREADY=0 is not accepted. The master must hold it; the block does not sample ARADDR until the handshake.
- RREADY high before RVALID is fine: the handshake completes in the first RVALID cycle.
- Reset mid-transaction: all outputs return to reset values on the next edge, the transaction is dropped, and no R beat is issued for it.

Optional Feature:
Macro AXILS_RD_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to REG_WAIT and increments each REG_WAIT cycle without ACK.
  - When it reaches TIMEOUT_CYC-1 with no ACK: RDATA<=0, RRESP<=2'b10 (SLVERR), RVALID<=1, go to RESP.
  - ACK in that same cycle wins (normal completion).
  - A later ACK is ignored.
- Undefined: no counter; REG_WAIT waits for ACK indefinitely.

Test Plan:
- Basic read: ARADDR=32'h0000_0010, ARVALID; local ACK in the REQ cycle with DATA=32'hCAFE_F00D, ERR=0 -> REG_RD_ADDR=10'h004, RVALID two cycles after the AR handshake, RDATA=32'hCAFE_F00D, RRESP=2'b00.
- Decode error: ARADDR=32'h0000_1000 (RANGE_W=12, BASE 0) -> no REG_RD_REQ, RVALID at N+1, RDATA=0, RRESP=2'b11.
- Slave error and wait states: ACK 5 cycles after REQ with ERR=1, DATA=32'h1234_5678 -> RRESP=2'b10, RDATA=32'h1234_5678; ARREADY stays 0 throughout.
- Backpressure: RREADY low for 4 cycles after RVALID -> RVALID/RDATA/RRESP stable; ARREADY=1 only after the handshake; back-to-back ARs at 0x0 and 0x4 both return correct data in order.
- Reset mid-op: assert ARESET while in REG_WAIT, then ACK after reset -> no RVALID, all outputs at reset values, ARREADY=1 one cycle after deassertion.
- With AXILS_RD_TIMEOUT_EN and TIMEOUT_CYC=8: no ACK -> RVALID with RRESP=2'b10, RDATA=0 after 8 REG_WAIT cycles; a late ACK is ignored; without the macro the block is still waiting after 100 cycles.
